// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//   Synchronises and glitch-filters the raw serial line, times each bit with a
//   counter, deframes start/data/parity/stop and hands the word to a consumer
//   over a valid/ready handshake with framing, parity and overrun flags.
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   data_raw     asynchronous serial line, idle high
//   data         synchronised and filtered line
//   state        FSM state: IDLE=0 START=1 DATA=2 PARITY=3 STOP=4
//   tmr          bit-timer value
//   rx_data      received word (LSB first on the line)
//   rx_valid     rx_data holds an unconsumed word
//   rx_ready     consumer accepts the word when rx_valid & rx_ready
//   frame_err    a stop bit of the word in rx_data was sampled 0
//   parity_err   the parity of the word in rx_data mismatched
//   overrun      1-cycle pulse: an unaccepted word was overwritten
module uart_rx_param #(
  parameter int unsigned BIT_CYCLES = 10,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_raw,
  output logic                          data,
  output logic [2:0]                    state,
  output logic [$clog2(BIT_CYCLES)-1:0] tmr,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned TW    = $clog2(BIT_CYCLES);
  localparam int unsigned CNT_W = 4;
  localparam logic [TW-1:0] TMR_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MID  = TW'(BIT_CYCLES / 2 - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Front end
  logic [1:0]            sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic [FILTER_LEN:0]   hist_ext;

  assign hist_ext = {hist_q, sync_q[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      hist_q <= '1;
      data   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], data_raw};
      hist_q <= hist_ext[FILTER_LEN-1:0];
      if (&hist_q)
        data <= 1'b1;
      else if (~|hist_q)
        data <= 1'b0;
    end
  end

  // Deframing FSM
  state_e               st_q, st_n;
  logic [TW-1:0]        tmr_q, tmr_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 pe_q, pe_n;
  logic                 fe_q, fe_n;
  logic                 armed_q, armed_n;
  logic                 deliver;

  assign state = st_q;
  assign tmr   = tmr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      st_q    <= st_n;
      tmr_q   <= tmr_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      pe_q    <= pe_n;
      fe_q    <= fe_n;
      armed_q <= armed_n;
    end
  end

  // armed_q blocks a new start until the line has been seen high after a
  // delivery, so a held-low break yields one word and then waits.
  always_comb begin
    st_n    = st_q;
    tmr_n   = (tmr_q == TMR_LAST) ? '0 : tmr_q + 1'b1;
    cnt_n   = cnt_q;
    shift_n = shift_q;
    pe_n    = pe_q;
    fe_n    = fe_q;
    armed_n = armed_q;
    deliver = 1'b0;
    case (st_q)
      S_IDLE: begin
        tmr_n = '0;
        if (data)
          armed_n = 1'b1;
        if (!data && armed_q) begin
          st_n = S_START;
          pe_n = 1'b0;
          fe_n = 1'b0;
        end
      end
      S_START: begin
        if (tmr_q == TMR_MID) begin
          tmr_n = '0;
          cnt_n = '0;
          st_n  = data ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tmr_q == TMR_LAST) begin
          shift_n = {data, shift_q[DATA_BITS-1:1]};
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            cnt_n = '0;
            st_n  = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (tmr_q == TMR_LAST) begin
          if (data != ((^shift_q) ^ PAR_ODD))
            pe_n = 1'b1;
          cnt_n = '0;
          st_n  = S_STOP;
        end
      end
      S_STOP: begin
        if (tmr_q == TMR_LAST) begin
          if (!data)
            fe_n = 1'b1;
          if (cnt_q == CNT_W'(STOP_BITS - 1)) begin
            deliver = 1'b1;
            armed_n = 1'b0;
            cnt_n   = '0;
            tmr_n   = '0;
            st_n    = S_IDLE;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        st_n  = S_IDLE;
        tmr_n = '0;
      end
    endcase
  end

  // Delivery and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver) begin
        rx_data    <= shift_q;
        frame_err  <= fe_n;
        parity_err <= pe_q;
        rx_valid   <= 1'b1;
        overrun    <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: two instances (8N1/10 cycles/bit and
// 8E2/7 cycles/bit), a frame-level reference model per instance checked
// every cycle, plus directed literal checks.
module tb_uart_rx_param;

  localparam int BC0 = 10;
  localparam int BC1 = 7;
  localparam int FL0 = 3;
  localparam int FL1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, raw0, raw1, rdy0, rdy1;
  logic       data0, data1, v0, v1, fe0, fe1, pe0, pe1, ov0, ov1;
  logic [2:0] state0, state1;
  logic [3:0] tmr0;
  logic [2:0] tmr1;
  logic [7:0] rxd0, rxd1;

  int compared = 0;
  int mismatched = 0;

  uart_rx_param u_dut0 (
    .clk(clk), .rst(rst), .data_raw(raw0), .data(data0), .state(state0),
    .tmr(tmr0), .rx_data(rxd0), .rx_valid(v0), .rx_ready(rdy0),
    .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx_param #(
    .BIT_CYCLES(BC1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FILTER_LEN(FL1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .data_raw(raw1), .data(data1), .state(state1),
    .tmr(tmr1), .rx_data(rxd1), .rx_valid(v1), .rx_ready(rdy1),
    .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since the start edge was seen; every
  // sample point and the state/timer follow from k by arithmetic.
  typedef struct packed {
    logic [9:0] rh;
    logic       d;
    logic       busy;
    logic       armed;
    int         k;
    logic [8:0] word;
    logic       pe;
    logic       fe;
    logic [8:0] rxd;
    logic       v;
    logic       rfe;
    logic       rpe;
    logic       ov;
    int         st;
    int         tmr;
  } mdl_t;

  mdl_t m0, m1;

  task automatic step(inout mdl_t m, input int bc, input int db, input int par,
                      input int sb, input int fl, input logic raw, input logic rdy,
                      input logic reset);
    logic d_old, all1, all0, x, expb, deliver;
    int half, idx, r;
    half = bc / 2;
    deliver = 1'b0;
    if (reset) begin
      m.rh = '1; m.d = 1'b1; m.busy = 1'b0; m.armed = 1'b1; m.k = 0;
      m.word = '0; m.pe = 1'b0; m.fe = 1'b0; m.rxd = '0; m.v = 1'b0;
      m.rfe = 1'b0; m.rpe = 1'b0; m.ov = 1'b0; m.st = 0; m.tmr = 0;
    end else begin
      d_old = m.d;
      all1 = 1'b1;
      all0 = 1'b1;
      for (int i = 2; i < fl + 2; i++) begin
        if (m.rh[i]) all0 = 1'b0;
        else all1 = 1'b0;
      end
      if (all1) m.d = 1'b1;
      else if (all0) m.d = 1'b0;
      m.rh = {m.rh[8:0], raw};
      if (!m.busy) begin
        if (m.armed && !d_old) begin
          m.busy = 1'b1; m.k = 0; m.word = '0; m.pe = 1'b0; m.fe = 1'b0;
        end else if (d_old) begin
          m.armed = 1'b1;
        end
      end else begin
        m.k++;
        if (m.k == half) begin
          if (d_old) m.busy = 1'b0;
        end else if (m.k > half && (m.k - half) % bc == 0) begin
          idx = (m.k - half) / bc - 1;
          if (idx < db) begin
            m.word[idx] = d_old;
          end else if (par != 0 && idx == db) begin
            x = 1'b0;
            for (int i = 0; i < db; i++) x ^= m.word[i];
            expb = (par == 1) ? !x : x;
            if (d_old !== expb) m.pe = 1'b1;
          end else begin
            if (!d_old) m.fe = 1'b1;
            if (idx == db + ((par != 0) ? 1 : 0) + sb - 1) begin
              deliver = 1'b1; m.busy = 1'b0; m.armed = 1'b0;
            end
          end
        end
      end
      m.ov = 1'b0;
      if (deliver) begin
        m.ov = m.v && !rdy;
        m.rxd = m.word; m.rfe = m.fe; m.rpe = m.pe; m.v = 1'b1;
      end else if (m.v && rdy) begin
        m.v = 1'b0;
      end
      if (!m.busy) begin
        m.st = 0; m.tmr = 0;
      end else if (m.k < half) begin
        m.st = 1; m.tmr = m.k;
      end else begin
        r = (m.k - half) / bc;
        m.tmr = (m.k - half) % bc;
        m.st = (r < db) ? 2 : ((par != 0 && r == db) ? 3 : 4);
      end
    end
  endtask

  // Compare process
  initial begin : compare
    forever begin
      @(posedge clk);
      step(m0, BC0, 8, 0, 1, FL0, raw0, rdy0, rst);
      step(m1, BC1, 8, 2, 2, FL1, raw1, rdy1, rst);
      #1;
      chk("d0.data", 32'(data0), 32'(m0.d));
      chk("d0.state", 32'(state0), 32'(m0.st));
      chk("d0.tmr", 32'(tmr0), 32'(m0.tmr));
      chk("d0.rx_valid", 32'(v0), 32'(m0.v));
      chk("d0.overrun", 32'(ov0), 32'(m0.ov));
      chk("d0.rx_data", 32'(rxd0), 32'(m0.rxd[7:0]));
      chk("d0.frame_err", 32'(fe0), 32'(m0.rfe));
      chk("d0.parity_err", 32'(pe0), 32'(m0.rpe));
      chk("d1.data", 32'(data1), 32'(m1.d));
      chk("d1.state", 32'(state1), 32'(m1.st));
      chk("d1.tmr", 32'(tmr1), 32'(m1.tmr));
      chk("d1.rx_valid", 32'(v1), 32'(m1.v));
      chk("d1.overrun", 32'(ov1), 32'(m1.ov));
      chk("d1.rx_data", 32'(rxd1), 32'(m1.rxd[7:0]));
      chk("d1.frame_err", 32'(fe1), 32'(m1.rfe));
      chk("d1.parity_err", 32'(pe1), 32'(m1.rpe));
    end
  end

  // Observation counters for the directed checks
  int vcnt0 = 0, vcnt1 = 0, ocnt0 = 0, lowcnt0 = 0, startcnt0 = 0;
  logic [7:0] capd0 = '0, capd1 = '0;
  logic capfe0 = 1'b0, cappe0 = 1'b0, capfe1 = 1'b0, cappe1 = 1'b0;

  always @(negedge clk) begin
    if (v0) begin vcnt0++; capd0 = rxd0; capfe0 = fe0; cappe0 = pe0; end
    if (v1) begin vcnt1++; capd1 = rxd1; capfe1 = fe1; cappe1 = pe1; end
    if (ov0) ocnt0++;
    if (!data0) lowcnt0++;
    if (state0 == 3'd1) startcnt0++;
  end

  task automatic hold(input int sel, input logic val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) raw0 = val;
      else raw1 = val;
    end
  endtask

  task automatic send0(input logic [7:0] b, input logic stopb);
    hold(0, 1'b0, BC0);
    for (int i = 0; i < 8; i++) hold(0, b[i], BC0);
    hold(0, stopb, BC0);
  endtask

  task automatic send1(input logic [7:0] b, input logic parb, input logic s1, input logic s2);
    hold(1, 1'b0, BC1);
    for (int i = 0; i < 8; i++) hold(1, b[i], BC1);
    hold(1, parb, BC1);
    hold(1, s1, BC1);
    hold(1, s2, BC1);
  endtask

  task automatic noisy_gap(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 19) == 0) hold(sel, 1'b0, $urandom_range(1, 4));
      else hold(sel, 1'b1, 1);
    end
  endtask

  int base, base2, rdone;
  logic [7:0] rb;

  initial begin : stim
    rst = 1'b1; raw0 = 1'b1; raw1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.state", 32'(state0), 32'd0);
    chk("rst.tmr", 32'(tmr0), 32'd0);
    chk("rst.data", 32'(data0), 32'd1);
    chk("rst.rx_valid", 32'(v0), 32'd0);
    chk("rst.rx_data", 32'(rxd0), 32'd0);
    chk("rst.flags", 32'({fe0, pe0, ov0}), 32'd0);
    rst = 1'b0;
    hold(0, 1'b1, 5);

    // 1: 0xA5, 8N1
    base = vcnt0;
    send0(8'hA5, 1'b1);
    hold(0, 1'b1, 3 * BC0);
    chk("t1.valid_cycles", 32'(vcnt0 - base), 32'd1);
    chk("t1.rx_data", 32'(capd0), 32'hA5);
    chk("t1.frame_err", 32'(capfe0), 32'd0);
    chk("t1.parity_err", 32'(cappe0), 32'd0);

    // 2: glitch filter and false start
    base = lowcnt0; base2 = startcnt0;
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 20);
    chk("t2.short_data_low", 32'(lowcnt0 - base), 32'd0);
    chk("t2.short_start", 32'(startcnt0 - base2), 32'd0);
    base = vcnt0; base2 = startcnt0;
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 30);
    chk("t2.long_start_seen", 32'(startcnt0 != base2), 32'd1);
    chk("t2.false_start_idle", 32'(state0), 32'd0);
    chk("t2.false_start_valid", 32'(vcnt0 - base), 32'd0);

    // 3: even parity on instance 1
    base = vcnt1;
    send1(8'h3C, 1'b1, 1'b1, 1'b1);
    hold(1, 1'b1, 3 * BC1);
    chk("t3.valid_cycles", 32'(vcnt1 - base), 32'd1);
    chk("t3.rx_data_bad", 32'(capd1), 32'h3C);
    chk("t3.parity_err_bad", 32'(cappe1), 32'd1);
    chk("t3.frame_err_bad", 32'(capfe1), 32'd0);
    send1(8'h3C, 1'b0, 1'b1, 1'b1);
    hold(1, 1'b1, 3 * BC1);
    chk("t3.rx_data_good", 32'(capd1), 32'h3C);
    chk("t3.parity_err_good", 32'(cappe1), 32'd0);

    // 4: framing error, then clean frame
    send0(8'h81, 1'b0);
    hold(0, 1'b1, 3 * BC0);
    chk("t4.rx_data_bad", 32'(capd0), 32'h81);
    chk("t4.frame_err_bad", 32'(capfe0), 32'd1);
    send0(8'h55, 1'b1);
    hold(0, 1'b1, 3 * BC0);
    chk("t4.rx_data_good", 32'(capd0), 32'h55);
    chk("t4.frame_err_good", 32'(capfe0), 32'd0);

    // 5: overrun
    rdy0 = 1'b0;
    base = ocnt0;
    send0(8'h11, 1'b1);
    hold(0, 1'b1, 2 * BC0);
    send0(8'h22, 1'b1);
    hold(0, 1'b1, 2 * BC0);
    chk("t5.overrun_pulses", 32'(ocnt0 - base), 32'd1);
    chk("t5.rx_data", 32'(rxd0), 32'h22);
    chk("t5.rx_valid_held", 32'(v0), 32'd1);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("t5.rx_valid_accepted", 32'(v0), 32'd0);
    chk("t5.rx_data_hold", 32'(rxd0), 32'h22);

    // 6: reset mid-frame
    base = vcnt0;
    hold(0, 1'b0, BC0);
    for (int i = 0; i < 4; i++) hold(0, 1'b0, BC0);   // 0xF0 bits 0..3
    hold(0, 1'b1, BC0 / 2);                           // half of bit 4
    chk("t6.in_data", 32'(state0), 32'd2);
    rst = 1'b1;
    raw0 = 1'b1;
    hold(0, 1'b1, 2);
    chk("t6.rst_state", 32'(state0), 32'd0);
    chk("t6.rst_valid", 32'(v0), 32'd0);
    rst = 1'b0;
    hold(0, 1'b1, 3 * BC0);
    send0(8'h0F, 1'b1);
    hold(0, 1'b1, 3 * BC0);
    chk("t6.valid_cycles", 32'(vcnt0 - base), 32'd1);
    chk("t6.rx_data", 32'(capd0), 32'h0F);
    chk("t6.frame_err", 32'(capfe0), 32'd0);

    // Randomized traffic on both instances
    rdone = 0;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          noisy_gap(0, $urandom_range(0, 25));
          hold(0, 1'b1, 2 * BC0);
          rb = 8'($urandom);
          if ($urandom_range(0, 9) == 0) hold(0, 1'b0, 12 * BC0);
          else send0(rb, $urandom_range(0, 7) != 0);
        end
        hold(0, 1'b1, 3 * BC0);
        rdone++;
      end
      begin
        logic [7:0] b1;
        for (int n = 0; n < 30; n++) begin
          noisy_gap(1, $urandom_range(0, 25));
          hold(1, 1'b1, 2 * BC1);
          b1 = 8'($urandom);
          send1(b1, (^b1) ^ ($urandom_range(0, 5) == 0),
                $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0);
        end
        hold(1, 1'b1, 3 * BC1);
        rdone++;
      end
      begin
        while (rdone < 2) begin
          @(negedge clk);
          rdy0 = $urandom_range(0, 3) != 0;
          rdy1 = $urandom_range(0, 3) != 0;
        end
      end
    join
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
